// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared constants for the PS/2 keyboard scan-code receiver.
//   FRAME_BITS           : bits per PS/2 frame (start, 8 data, parity, stop)
//   BREAK_CODE           : 0xF0 key-release prefix, passed through undecoded
//   EXTEND_CODE          : 0xE0 extended-key prefix, passed through undecoded
//   DEFAULT_FIFO_DEPTH   : default scan-code FIFO depth (power of 2)
//   DEFAULT_TIMEOUT_CYC  : default partial-frame timeout (1 ms at 50 MHz)
//   frame_ok()           : start/stop/odd-parity check of a complete frame
// ----------------------------------------------------------------------------
package ps2_pkg;

    localparam int         FRAME_BITS          = 11;
    localparam logic [7:0] BREAK_CODE          = 8'hF0;
    localparam logic [7:0] EXTEND_CODE         = 8'hE0;
    localparam int         DEFAULT_FIFO_DEPTH  = 8;
    localparam int         DEFAULT_TIMEOUT_CYC = 50000;

    // f[0] = start, f[8:1] = data (LSB first), f[9] = parity, f[10] = stop.
    // Odd parity: the data bits plus the parity bit hold an odd number of ones.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
        return ~f[0] & f[10] & (^f[9:1]);
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// ----------------------------------------------------------------------------
// ps2_fifo
// Scan-code FIFO with DEPTH-1 usable entries (one slot kept empty so that
// full and empty are distinguishable from the pointers alone).
//   clk      : system clock, rising edge
//   clrn     : synchronous active-low reset (pointers only; storage kept)
//   wr_en    : push request; ignored when full unless a pop happens too
//   wr_data  : byte to push
//   rd_en    : pop request; ignored when empty
//   rd_data  : byte at the head, combinational from storage
//   ready    : FIFO non-empty
//   full     : FIFO holds DEPTH-1 entries
// ----------------------------------------------------------------------------
module ps2_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       ready,
    output logic       full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] w_ptr_reg;
    logic [PTR_W-1:0] r_ptr_reg;
    logic             do_write;
    logic             do_read;

    assign ready   = (w_ptr_reg != r_ptr_reg);
    assign full    = (PTR_W'(w_ptr_reg + 1'b1) == r_ptr_reg);
    assign do_read = rd_en & ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_write = wr_en & (~full | do_read);
    assign rd_data  = mem[r_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[w_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            w_ptr_reg <= '0;
            r_ptr_reg <= '0;
        end else begin
            if (do_write) begin
                w_ptr_reg <= w_ptr_reg + 1'b1;
            end
            if (do_read) begin
                r_ptr_reg <= r_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scan_rx.sv
// ----------------------------------------------------------------------------
// ps2_scan_rx
// PS/2 keyboard receiver: synchronizes the keyboard pins, assembles 11-bit
// frames on ps2_clk falling edges, checks start/stop/odd parity and queues
// good scan codes in a FIFO. Prefix codes (0xF0, 0xE0) are ordinary entries.
//   clk        : 50 MHz system clock, rising edge
//   clrn       : synchronous active-low reset
//   ps2_clk    : keyboard clock pin (asynchronous, idle high)
//   ps2_data   : keyboard data pin (asynchronous, idle high)
//   nextdata_n : active-low pop request for the FIFO head
//   data       : scan code at the FIFO head
//   ready      : FIFO non-empty, data valid
//   overflow   : sticky, a good frame was dropped because the FIFO was full
//   parity_err : one-cycle pulse when a frame is rejected
// ----------------------------------------------------------------------------
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       parity_err
);

    localparam int CNT_W = $clog2(FRAME_BITS);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]       clk_sync_reg;
    logic [2:0]       data_sync_reg;
    logic [CNT_W-1:0] count_reg;
    logic [TO_W-1:0]  timeout_reg;
    logic [9:0]       buffer_reg;
    logic             overflow_reg;
    logic             parity_err_reg;

    logic             fall;
    logic             data_bit;
    logic             frame_done;
    logic             frame_good;
    logic             pop;
    logic             fifo_full;

    // Stages [0],[1] form the synchronizer; [2] is the delayed copy used for
    // edge detection. Data is taken from stage [2] so it is the value that
    // was on the pin a cycle before the clock edge was seen.
    assign fall     = clk_sync_reg[2] & ~clk_sync_reg[1];
    assign data_bit = data_sync_reg[2];

    assign frame_done = fall && (count_reg == CNT_W'(FRAME_BITS - 1));
    assign frame_good = frame_done && frame_ok({data_bit, buffer_reg});
    assign pop        = ready & ~nextdata_n;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            clk_sync_reg  <= '1;
            data_sync_reg <= '1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[1:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[1:0], ps2_data};
        end
    end

    // Bit counter, shift buffer and partial-frame timeout.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            count_reg   <= '0;
            timeout_reg <= '0;
            buffer_reg  <= '0;
        end else if (fall) begin
            timeout_reg <= '0;
            buffer_reg  <= {data_bit, buffer_reg[9:1]};
            if (frame_done) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end else if (count_reg != '0) begin
            // A stalled frame is silently abandoned so the next one aligns.
            if (timeout_reg == TO_W'(TIMEOUT_CYC - 1)) begin
                count_reg   <= '0;
                timeout_reg <= '0;
            end else begin
                timeout_reg <= timeout_reg + 1'b1;
            end
        end else begin
            timeout_reg <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            overflow_reg   <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            parity_err_reg <= frame_done & ~frame_good;
            if (frame_good && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .wr_en   (frame_good),
        .wr_data (buffer_reg[8:1]),
        .rd_en   (pop),
        .rd_data (data),
        .ready   (ready),
        .full    (fifo_full)
    );

    assign overflow   = overflow_reg;
    assign parity_err = parity_err_reg;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// ----------------------------------------------------------------------------
// tb_ps2_scan_rx
// Directed and randomized PS/2 frames against a queue-based reference model
// of the scan-code FIFO. The keyboard clock is scaled down (40 clk per bit)
// and the timeout shortened so the run stays short.
// ----------------------------------------------------------------------------
module tb_ps2_scan_rx;

    localparam int DEPTH = 8;
    localparam int TO    = 200;
    localparam int HALF  = 20;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    byte unsigned model_q[$];
    bit           model_ovf = 1'b0;
    int           perr_cycles;
    int           rdy_lat;

    always #5 clk = ~clk;

    ps2_scan_rx #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .parity_err (parity_err)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame as transmitted: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad);
        logic par;
        par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        if (bad) par = ~par;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            wait_clk(HALF);
            ps2_clk = 1'b0;
            wait_clk(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    // Final (stop) bit; watches parity_err / ready while ps2_clk is low and
    // can pop on the cycle the frame is written (third clk after the edge).
    task automatic last_edge(input bit stop, input bit pop_on_write);
        ps2_data = stop;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        perr_cycles = 0;
        rdy_lat = -1;
        for (int i = 1; i <= HALF; i++) begin
            if (pop_on_write) nextdata_n = (i == 3) ? 1'b0 : 1'b1;
            wait_clk(1);
            if (parity_err === 1'b1) perr_cycles++;
            if (ready === 1'b1 && rdy_lat < 0) rdy_lat = i;
        end
        nextdata_n = 1'b1;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_ready"}, ready, (model_q.size() != 0));
        if (model_q.size() != 0) check({tag, "_data"}, data, model_q[0]);
        check({tag, "_overflow"}, overflow, model_ovf);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad, input bit pop_on_write);
        logic [10:0] f;
        bit          was_empty;
        f = make_frame(b, bad);
        was_empty = (model_q.size() == 0);
        send_bits(f, 10);
        last_edge(f[10], pop_on_write);
        if (pop_on_write && model_q.size() != 0) void'(model_q.pop_front());
        if (!bad) begin
            if (model_q.size() < DEPTH - 1) model_q.push_back(b);
            else model_ovf = 1'b1;
        end
        $display("frame 0x%02h bad=%0d pop=%0d ready=%0d data=0x%02h ovf=%0d perr_cycles=%0d",
                 b, bad, pop_on_write, ready, data, overflow, perr_cycles);
        check("parity_err_pulse", perr_cycles, bad ? 1 : 0);
        if (was_empty && !bad && !pop_on_write)
            check("ready_latency", (rdy_lat >= 1 && rdy_lat <= 4), 1);
        check_model("frame");
    endtask

    task automatic do_pop();
        nextdata_n = 1'b0;
        wait_clk(1);
        nextdata_n = 1'b1;
        if (model_q.size() != 0) void'(model_q.pop_front());
        $display("pop ready=%0d data=0x%02h", ready, data);
        check_model("pop");
    endtask

    initial begin
        logic [7:0] rb;
        bit         rbad;

        // Reset state
        clrn = 1'b0;
        wait_clk(3);
        check("reset_ready", ready, 0);
        check("reset_overflow", overflow, 0);
        check("reset_parity_err", parity_err, 0);
        clrn = 1'b1;
        wait_clk(2);

        // Single frame 0x1C, then pop
        send_frame(8'h1C, 0, 0);
        check("first_data", data, 8'h1C);
        do_pop();

        // Break prefix then code, popped in order
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        check("prefix_head", data, 8'hF0);
        do_pop();
        do_pop();

        // Bad parity rejected, then good 0x5A stored
        send_frame(8'h5A, 1, 0);
        send_frame(8'h5A, 0, 0);
        do_pop();

        // Randomized frames with occasional pops
        repeat (8) begin
            rb = 8'($urandom);
            rbad = ($urandom_range(0, 3) == 0);
            send_frame(rb, rbad, 0);
            if ($urandom_range(0, 1) == 1) do_pop();
        end
        while (model_q.size() != 0) do_pop();

        // Partial frame timeout, then 0x29 received normally
        send_bits(make_frame(8'h33, 0), 5);
        wait_clk(TO + 1);
        send_frame(8'h29, 0, 0);
        check("timeout_data", data, 8'h29);
        do_pop();

        // Fill to overflow, then write with a simultaneous pop while full
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 0);
        check("overflow_set", overflow, 1);
        send_frame(8'h09, 0, 1);
        check("full_pop_push_head", data, 8'h02);
        while (model_q.size() > 3) do_pop();

        // Reset mid-frame with 3 entries queued
        send_bits(make_frame(8'hAA, 0), 6);
        clrn = 1'b0;
        wait_clk(2);
        clrn = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        wait_clk(1);
        check_model("after_reset");
        check("after_reset_parity_err", parity_err, 0);
        send_frame(8'h75, 0, 0);
        check("post_reset_data", data, 8'h75);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, scan-code FIFO entries (power of 2; FIFO_DEPTH-1 usable).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, clk cycles without a ps2_clk falling edge before a partial frame is discarded (1 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz; sole clock, all state on rising edge.
REQ-004 SHALL have port clrn  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port ps2_clk  input  1  keyboard clock pin, asynchronous, idle high.
REQ-006 SHALL have port ps2_data  input  1  keyboard data pin, asynchronous, idle high.
REQ-007 SHALL have port nextdata_n  input  1  consumer pop request, active-low.
REQ-008 SHALL have port data  output  8  scan code at FIFO head.
REQ-009 SHALL have port ready  output  1  FIFO non-empty; data valid.
REQ-010 SHALL have port overflow  output  1  sticky: a valid frame was dropped on full FIFO.
REQ-011 SHALL have port parity_err  output  1  one-cycle pulse on rejected frame.

Function
REQ-012 SHALL pass ps2_clk and ps2_data through 3-stage synchronizers; falling edge = stage2 high and stage1 low (edge-detect pair after 2-flop synchronizer).
REQ-013 SHALL, per detected falling edge, shift synchronized ps2_data into a 10-bit buffer LSB-first and increment bit count 0..10.
REQ-014 SHALL, on the edge with count==10, evaluate the frame: start bit 0, stop bit 1, odd parity over 8 data bits plus parity bit; count returns to 0 in the same cycle.
REQ-015 SHALL write a good frame's 8 data bits into the FIFO on that cycle; ready rises the following cycle (at most 4 clk after the 11th pin falling edge).
REQ-016 SHALL drop a bad frame (start, stop or parity fault), pulse parity_err high for exactly one clk, and leave FIFO untouched.
REQ-017 SHALL, with count nonzero and TIMEOUT_CYC cycles elapsed since the last edge, reset count to 0, discard the partial frame, and raise no flag.
REQ-018 SHALL present data = FIFO[r_ptr] combinationally; ready = (w_ptr != r_ptr).
REQ-019 SHALL pop (r_ptr+1, modulo FIFO_DEPTH) on any rising clk with ready high and nextdata_n low; pop with ready low is ignored.
REQ-020 SHALL treat the FIFO as full when w_ptr+1 == r_ptr; a good frame arriving while full and with no same-cycle pop is dropped and sets overflow.
REQ-021 SHALL accept a write and a pop in the same cycle, including when full; both pointers advance.
REQ-022 SHALL hold overflow high until clrn; it does not block subsequent writes once space exists.
REQ-023 SHALL pass 0xF0 and 0xE0 prefix codes through as ordinary entries; no decoding of scan codes.

Reset
REQ-024 SHALL on clrn low at a rising edge: w_ptr=r_ptr=0, count=0, timeout counter=0, buffer=0, ready=0, overflow=0, parity_err=0, synchronizer stages=1.
REQ-025 SHALL abandon any partial frame when reset is asserted mid-frame; first complete frame after release is received normally.
REQ-026 SHALL leave data as the content of FIFO[0] after reset (don't-care while ready=0).

Structure
REQ-027 SHALL place in shared package ps2_pkg: frame length 11, break code 8'hF0, extend code 8'hE0, default FIFO depth and timeout constants.
REQ-028 SHALL implement the FIFO as sub-module ps2_fifo (storage, pointers, full/empty, simultaneous push/pop); framing, synchronizer and timeout stay in ps2_scan_rx.

Verification
REQ-029 SHALL cover: frame 0x1C (parity 0), 20 kHz ps2_clk -> ready high within 4 clk of 11th edge, data=0x1C; one-cycle nextdata_n low -> ready 0.
REQ-030 SHALL cover: frames 0xF0 then 0x1C, no pops -> data 0xF0 first, after pop 0x1C, after second pop ready 0.
REQ-031 SHALL cover: frame 0x5A with parity bit 0 -> parity_err one-cycle pulse, ready stays 0; next good frame 0x5A (parity 1) stored.
REQ-032 SHALL cover: 8 good frames 0x01..0x08, no pops -> entries 0x01..0x07 stored, overflow=1, 0x08 absent; pop with simultaneous 9th frame 0x09 -> both occur, overflow stays 1.
REQ-033 SHALL cover: 5 edges then TIMEOUT_CYC+1 idle clk, then full frame 0x29 -> data=0x29, no parity_err.
REQ-034 SHALL cover: clrn low after 6 bits of a frame with 3 entries queued -> ready 0, overflow 0; next frame 0x75 -> data=0x75.
